// File: rtl/apb_pkg.sv
// Shared definitions for the multi-slave APB master: FSM state encoding
// and the PENABLE levels that distinguish the two APB transfer phases.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // PENABLE level during each APB phase
    localparam logic PHASE_SETUP  = 1'b0;
    localparam logic PHASE_ACCESS = 1'b1;

endpackage

// File: rtl/apb_master_nslv_if.sv
// User request/response handshake plus the shared APB bus towards NSLV slaves.
// The master modport is the APB master's view; slave is the environment's view.
interface apb_master_nslv_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int NSLV   = 3
) ();

    // user request / response side
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [ADDR_W-1:0]      req_addr;
    logic [DATA_W-1:0]      req_wdata;
    logic                   rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;

    // APB side
    logic [NSLV-1:0]        PSEL;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [ADDR_W-1:0]      PADDR;
    logic [DATA_W-1:0]      PWDATA;
    logic [NSLV-1:0]        PREADY;
    logic [NSLV-1:0]        PSLVERR;
    logic [NSLV*DATA_W-1:0] PRDATA;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  PREADY, PSLVERR, PRDATA,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output PREADY, PSLVERR, PRDATA,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_addr_decode.sv
// Slave index decoder: turns the top address bits into a one-hot select
// and flags indices that do not correspond to an implemented slave.
module apb_addr_decode #(
    parameter int NSLV  = 3,
    parameter int IDX_W = 2
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [NSLV-1:0]  sel_o,
    output logic             dec_err_o
);

    logic [31:0] idx_ext;

    assign idx_ext = 32'(idx_i);

    generate
        for (genvar gi = 0; gi < NSLV; gi++) begin : g_sel
            assign sel_o[gi] = (idx_ext == 32'(gi));
        end
    endgenerate

    // an out-of-range index selects nothing and is reported instead
    assign dec_err_o = (idx_ext >= 32'(NSLV));

endmodule

// File: rtl/apb_master_nslv.sv
// APB master fanning out to NSLV slaves. One user request at a time is turned
// into a SETUP/ACCESS transfer to the slave chosen by the top address bits,
// with an optional ACCESS wait timeout. Every output comes straight from a flop.
module apb_master_nslv
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int NSLV    = 3,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    apb_master_nslv_if.master bus
);

    // wait counter must be able to hold TIMEOUT itself
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    apb_state_e        state_q, state_d;
    logic [NSLV-1:0]   psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              req_ready_q, req_ready_d;

    logic [NSLV-1:0]   dec_sel;
    logic              dec_err;
    logic              pready_sel;
    logic              pslverr_sel;
    logic [DATA_W-1:0] prdata_part [NSLV];
    logic [DATA_W-1:0] prdata_sel;
    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout_hit;
    logic              accept;

    apb_addr_decode #(
        .NSLV  (NSLV),
        .IDX_W (IDX_W)
    ) u_decode (
        .idx_i     (bus.req_addr[ADDR_W-1 -: IDX_W]),
        .sel_o     (dec_sel),
        .dec_err_o (dec_err)
    );

    // Responses are gated by the registered one-hot select, so only the
    // slave currently being addressed can influence the master.
    assign pready_sel  = |(bus.PREADY  & psel_q);
    assign pslverr_sel = |(bus.PSLVERR & psel_q);

    generate
        for (genvar gi = 0; gi < NSLV; gi++) begin : g_rdata
            assign prdata_part[gi] = bus.PRDATA[gi*DATA_W +: DATA_W] & {DATA_W{psel_q[gi]}};
        end
    endgenerate

    // OR the masked per-slave read data into the selected slave's word
    always_comb begin
        prdata_sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            prdata_sel = prdata_sel | prdata_part[i];
        end
    end

    // saturating increment so the counter never wraps, even with no timeout
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign timeout_hit = (TIMEOUT > 0) && (cnt_inc == CNT_LIMIT);
    assign accept      = bus.req_valid && req_ready_q;

    // next-state and next-output logic; everything holds unless changed
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    pwrite_d = bus.req_write;
                    paddr_d  = bus.req_addr;
                    pwdata_d = bus.req_wdata;
                    if (dec_err) begin
                        // no such slave: answer immediately without touching the bus
                        state_d     = ST_RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d   = ST_SETUP;
                        psel_d    = dec_sel;
                        penable_d = PHASE_SETUP;
                        cnt_d     = '0;
                    end
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = PHASE_ACCESS;
            end
            ST_ACCESS: begin
                if (pready_sel) begin
                    // a ready slave wins even on the cycle the timeout would fire
                    state_d     = ST_RESP;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_err_d   = pslverr_sel;
                    rsp_rdata_d = (pwrite_q || pslverr_sel) ? '0 : prdata_sel;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        state_d     = ST_RESP;
                        psel_d      = '0;
                        penable_d   = 1'b0;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rsp_valid_d = (state_d == ST_RESP);
        req_ready_d = (state_d == ST_IDLE);
    end

    // state and output registers with asynchronous reset
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;

endmodule

// File: doc/apb_master_nslv.md
APB_MASTER_NSLV -- requirements
Module: apb_master_nslv

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, APB address width.
REQ-002 SHALL have parameter DATA_W, default 8, APB data width.
REQ-003 SHALL have parameter NSLV, default 3, number of slaves (1..2**IDX_W).
REQ-004 SHALL have parameter IDX_W, default 2, top address bits used as slave index.
REQ-005 SHALL have parameter TIMEOUT, default 16, max ACCESS wait cycles (0 = no timeout).
REQ-006 SHALL have one clock and an asynchronous, active-low reset: PCLK, PRESETn.
REQ-007 PCLK  in  1  clock; all state changes on rising edge.
REQ-008 PRESETn  in  1  async active-low reset.
REQ-009 req_valid  in  1  user transfer request.
REQ-010 req_ready  out  1  request accepted when req_valid & req_ready.
REQ-011 req_write  in  1  1 = write, 0 = read.
REQ-012 req_addr  in  ADDR_W  transfer address; [ADDR_W-1 -: IDX_W] = slave index.
REQ-013 req_wdata  in  DATA_W  write data.
REQ-014 rsp_valid  out  1  one-cycle completion pulse.
REQ-015 rsp_rdata  out  DATA_W  read data (0 for writes and errors).
REQ-016 rsp_err  out  1  completion error (PSLVERR, decode or timeout).
REQ-017 PSEL  out  NSLV  one-hot slave select.
REQ-018 PENABLE, PWRITE  out  1 each  APB access phase, direction.
REQ-019 PADDR  out  ADDR_W; PWDATA  out  DATA_W  APB address, write data.
REQ-020 PREADY, PSLVERR  in  NSLV each; PRDATA  in  NSLV*DATA_W  per-slave responses, slave i at [i*DATA_W +: DATA_W].

Function
REQ-021 FSM states SHALL be IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-022 req_ready SHALL be 1 only in IDLE; acceptance latches write, addr, wdata, index.
REQ-023 Accepted index < NSLV: IDLE->SETUP; PSEL[index]=1, PENABLE=0, PADDR/PWRITE/PWDATA driven.
REQ-024 SETUP->ACCESS unconditionally; PENABLE=1; PSEL, PADDR, PWRITE, PWDATA stable throughout ACCESS.
REQ-025 In ACCESS, only selected slave's PREADY/PSLVERR/PRDATA SHALL be sampled; others ignored.
REQ-026 PREADY=1 in ACCESS: capture PRDATA (reads only) and PSLVERR, clear PSEL/PENABLE, ->RESP.
REQ-027 RESP SHALL assert rsp_valid for exactly one cycle, then ->IDLE; rsp_* hold until next RESP.
REQ-028 Zero-wait latency: rsp_valid high in 3rd cycle after acceptance edge; +1 per wait cycle.
REQ-029 Index >= NSLV: no PSEL asserted, IDLE->RESP directly, rsp_err=1, rsp_rdata=0 (1-cycle latency).
REQ-030 Wait counter SHALL clear on SETUP entry, increment per ACCESS cycle with PREADY=0.
REQ-031 TIMEOUT>0 and counter reaches TIMEOUT: PSEL/PENABLE cleared, ->RESP, rsp_err=1, rsp_rdata=0.
REQ-032 PREADY arriving in the same cycle the counter reaches TIMEOUT SHALL win (normal completion).
REQ-033 Counter width SHALL be $clog2(TIMEOUT+1); no wrap-around.

Reset
REQ-034 PRESETn low SHALL immediately force IDLE, counter 0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0.
REQ-035 Reset mid-transfer SHALL abort without rsp_valid; req_ready=1 from first edge after release.

Structure
REQ-036 Shared package apb_pkg SHALL hold the FSM state enum and APB phase constants.
REQ-037 Sub-module apb_addr_decode SHALL map index to one-hot PSEL and a decode-error flag.

Verification
REQ-038 Write 0xD9 to addr 0x13C (slave 2), PREADY tied 1 -> PSEL=3'b100, 1 SETUP + 1 ACCESS, rsp_valid cycle 3, rsp_err=0.
REQ-039 Read addr 0x036 (slave 0), PRDATA0=0x9D, PREADY after 3 waits -> rsp_rdata=0x9D, rsp_valid cycle 6.
REQ-040 Request addr 0x1DE (index 3) -> PSEL stays 0, rsp_valid cycle 1, rsp_err=1, rsp_rdata=0.
REQ-041 Slave 1 PREADY held 0, TIMEOUT=16 -> 16 ACCESS cycles, PSEL cleared, rsp_err=1.
REQ-042 Slave 1 PSLVERR=1 with PREADY -> rsp_err=1; then PRESETn pulsed in ACCESS -> all outputs 0, no rsp_valid.
